// File: rtl/zbus_strobe_filter.sv
// ZX-bus read/write strobe conditioner: synchronise, deglitch, then sequence
// buffered brd_n/bwr_n with write-length limiting and inter-strobe recovery.
module zbus_strobe_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH      = 2,
  parameter int WR_MAX      = 6,
  parameter int RECOVER     = 1
) (
  input  logic fclk,
  input  logic rst,
  input  logic zrd_n,
  input  logic zwr_n,
  input  logic clr_err,
  output logic brd_n,
  output logic bwr_n,
  output logic wr_done,
  output logic busy,
  output logic err_overlap
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_WR     = 3'd2;
  localparam logic [2:0] S_WAITWR = 3'd3;
  localparam logic [2:0] S_REC    = 3'd4;

  localparam logic [2:0] GLITCH_C  = 3'(GLITCH);
  localparam logic [3:0] WR_MAX_C  = 4'(WR_MAX);
  localparam logic [2:0] RECOVER_C = 3'(RECOVER);

  logic [SYNC_STAGES-1:0] rd_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic                   rd_s;
  logic                   wr_s;

  logic [2:0] rd_cnt;
  logic [2:0] wr_cnt;
  logic       rf;
  logic       wf;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [2:0] rec_target;
  logic [3:0] wcnt;
  logic [2:0] rcnt;
  logic       set_err;
  logic       wr_exit;

  // NOTE: every sequential block below uses non-blocking assignments so all
  // flops sample pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge fclk) begin
    if (rst) begin
      rd_sync <= '1;
      wr_sync <= '1;
    end else begin
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], zrd_n};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], zwr_n};
    end
  end

  assign rd_s = rd_sync[SYNC_STAGES-1];
  assign wr_s = wr_sync[SYNC_STAGES-1];

  // Slow attack, fast release: low only after GLITCH consecutive low samples.
  always_ff @(posedge fclk) begin
    if (rst) begin
      rd_cnt <= '0;
      rf     <= 1'b1;
    end else if (rd_s) begin
      rd_cnt <= '0;
      rf     <= 1'b1;
    end else if (rd_cnt != GLITCH_C) begin
      rd_cnt <= rd_cnt + 3'd1;
      if (rd_cnt == GLITCH_C - 3'd1) rf <= 1'b0;
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      wr_cnt <= '0;
      wf     <= 1'b1;
    end else if (wr_s) begin
      wr_cnt <= '0;
      wf     <= 1'b1;
    end else if (wr_cnt != GLITCH_C) begin
      wr_cnt <= wr_cnt + 3'd1;
      if (wr_cnt == GLITCH_C - 3'd1) wf <= 1'b0;
    end
  end

  assign rec_target = (RECOVER == 0) ? S_IDLE : S_REC;

  // NOTE: all combinational outputs get a default first so no path can
  // infer a latch.
  always_comb begin
    state_nxt = state;
    set_err   = 1'b0;
    wr_exit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rf && !wf)  set_err   = 1'b1;
        else if (!rf)    state_nxt = S_RD;
        else if (!wf)    state_nxt = S_WR;
      end
      S_RD: begin
        if (!wf) set_err   = 1'b1;
        if (rf)  state_nxt = rec_target;
      end
      S_WR: begin
        if (!rf) set_err = 1'b1;
        if (wf || wcnt == 4'd1) begin
          wr_exit   = 1'b1;
          state_nxt = wf ? rec_target : S_WAITWR;
        end
      end
      S_WAITWR: begin
        if (wf) state_nxt = rec_target;
      end
      S_REC: begin
        if (rcnt <= 3'd1) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they are registered and
  // mutually exclusive by construction.
  always_ff @(posedge fclk) begin
    if (rst) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      rcnt        <= '0;
      brd_n       <= 1'b1;
      bwr_n       <= 1'b1;
      wr_done     <= 1'b0;
      err_overlap <= 1'b0;
    end else begin
      state   <= state_nxt;
      brd_n   <= (state_nxt != S_RD);
      bwr_n   <= (state_nxt != S_WR);
      wr_done <= wr_exit;

      if (state != S_WR && state_nxt == S_WR) wcnt <= WR_MAX_C;
      else if (state == S_WR)                 wcnt <= wcnt - 4'd1;

      if (state != S_REC && state_nxt == S_REC) rcnt <= RECOVER_C;
      else if (state == S_REC)                  rcnt <= rcnt - 3'd1;

      if (set_err)      err_overlap <= 1'b1;
      else if (clr_err) err_overlap <= 1'b0;
    end
  end

  assign busy = (state != S_IDLE);

endmodule
